// File: rtl/counter_checker.sv
// counter_checker: cycle-accurate reference monitor for the 4-bit multi-mode
// counter (MODO 00 +1, 01 -1, 10 +3, 11 load). The counter has no reset, so
// the checker waits in UNSYNC for a parallel load, then checks Q, RCO and
// Paridad on every edge, realigning its model after each mismatch so that
// one fault produces exactly one error.
//
// Optional feature macro: PARITY_CHECK_EN
//   defined   - expected parity is tracked and Paridad is compared.
//   undefined - no parity model, ERR_PAR stays 0 and Paridad is ignored.
module counter_checker #(
    parameter int CNT_W = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENB,
    input  logic [3:0]       D,
    input  logic [1:0]       MODO,
    input  logic [3:0]       Q,
    input  logic             RCO,
    input  logic             Paridad,
    output logic             SYNC,
    output logic             ERR_Q,
    output logic             ERR_RCO,
    output logic             ERR_PAR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] ERR_CNT
);

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Even parity (XOR reduction) of a counter value.
    function automatic logic parity4(input logic [3:0] v);
        return ^v;
    endfunction

    // One step of the counter: value after an edge with the given controls.
    function automatic logic [3:0] count_step(
        input logic [3:0] base,
        input logic       enb,
        input logic [1:0] modo,
        input logic [3:0] din
    );
        logic [3:0] nxt;
        nxt = base;
        if (enb) begin
            case (modo)
                2'b00:   nxt = base + 4'd1;
                2'b01:   nxt = base - 4'd1;
                2'b10:   nxt = base + 4'd3;
                2'b11:   nxt = din;
                default: nxt = base;
            endcase
        end else begin
            nxt = base;
        end
        return nxt;
    endfunction

    state_t           state_q;
    logic [3:0]       exp_val_q;
    logic             sync_q;
    logic             err_q_flag_q;
    logic             err_rco_flag_q;
    logic             err_par_flag_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic             mq_s;
    logic             mr_s;
    logic             mp_s;
    logic             any_err_s;
    logic             load_s;
    logic [3:0]       base_q_s;
    logic [3:0]       exp_val_d;
    logic [CNT_W-1:0] err_cnt_d;

`ifdef PARITY_CHECK_EN
    logic exp_par_q;
    logic exp_par_d;
    logic base_p_s;

    // Parity mismatch, realigned parity base and next expected parity.
    always_comb begin
        mp_s      = (Paridad != exp_par_q);
        base_p_s  = mp_s ? Paridad : exp_par_q;
        exp_par_d = base_p_s;
        if (ENB) begin
            exp_par_d = base_p_s ^ parity4(base_q_s);
        end else begin
            exp_par_d = base_p_s;
        end
    end

    // Expected parity register: seeded at the sync load, stepped in CHECK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            exp_par_q <= 1'b0;
        end else begin
            case (state_q)
                ST_UNSYNC: begin
                    if (load_s) begin
                        exp_par_q <= Paridad ^ parity4(Q);
                    end else begin
                        exp_par_q <= exp_par_q;
                    end
                end
                ST_CHECK: exp_par_q <= exp_par_d;
                default:  exp_par_q <= 1'b0;
            endcase
        end
    end
`else
    // Paridad may be X on benches with an unreset counter; it is not used.
    logic unused_paridad_s;
    assign unused_paridad_s = Paridad;
    assign mp_s             = 1'b0;
`endif

    // Q/RCO mismatch detection, realignment and next expected count value.
    always_comb begin
        mq_s      = (Q != exp_val_q);
        // RCO is judged against the observed Q so a Q fault does not also flag RCO.
        mr_s      = (RCO != (Q == 4'hF));
        any_err_s = mq_s | mr_s | mp_s;
        load_s    = ENB & (MODO == 2'b11);
        base_q_s  = mq_s ? Q : exp_val_q;
        exp_val_d = count_step(base_q_s, ENB, MODO, D);
        if (any_err_s && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Sync/check state machine with registered error outputs.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= ST_UNSYNC;
            exp_val_q      <= 4'h0;
            sync_q         <= 1'b0;
            err_q_flag_q   <= 1'b0;
            err_rco_flag_q <= 1'b0;
            err_par_flag_q <= 1'b0;
            err_sticky_q   <= 1'b0;
            err_cnt_q      <= {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_UNSYNC: begin
                    err_q_flag_q   <= 1'b0;
                    err_rco_flag_q <= 1'b0;
                    err_par_flag_q <= 1'b0;
                    err_sticky_q   <= err_sticky_q;
                    err_cnt_q      <= err_cnt_q;
                    if (load_s) begin
                        state_q   <= ST_CHECK;
                        exp_val_q <= D;
                        sync_q    <= 1'b1;
                    end else begin
                        state_q   <= ST_UNSYNC;
                        exp_val_q <= exp_val_q;
                        sync_q    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    state_q        <= ST_CHECK;
                    exp_val_q      <= exp_val_d;
                    sync_q         <= 1'b1;
                    err_q_flag_q   <= mq_s;
                    err_rco_flag_q <= mr_s;
                    err_par_flag_q <= mp_s;
                    err_sticky_q   <= err_sticky_q | any_err_s;
                    err_cnt_q      <= err_cnt_d;
                end
                default: begin
                    state_q        <= ST_UNSYNC;
                    exp_val_q      <= 4'h0;
                    sync_q         <= 1'b0;
                    err_q_flag_q   <= 1'b0;
                    err_rco_flag_q <= 1'b0;
                    err_par_flag_q <= 1'b0;
                    err_sticky_q   <= 1'b0;
                    err_cnt_q      <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign SYNC       = sync_q;
    assign ERR_Q      = err_q_flag_q;
    assign ERR_RCO    = err_rco_flag_q;
    assign ERR_PAR    = err_par_flag_q;
    assign ERR_STICKY = err_sticky_q;
    assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: a behavioural 4-bit counter drives Q/RCO/Paridad,
// faults are planted by corrupting that counter's state or its RCO output.
// Two checkers (CNT_W=8 and CNT_W=2) watch the same nets; expected outputs are
// pushed to a scoreboard queue when a cycle is driven and popped after the edge.
module tb_counter_checker;

    logic       CLK = 1'b0;
    logic       RESET, ENB, RCO, Paridad;
    logic [3:0] D, Q;
    logic [1:0] MODO;

    logic       sync8, eq8, er8, ep8, st8;
    logic [7:0] cnt8;
    logic       sync2, eq2, er2, ep2, st2;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

`ifdef PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    counter_checker #(.CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .D(D), .MODO(MODO), .Q(Q), .RCO(RCO),
        .Paridad(Paridad), .SYNC(sync8), .ERR_Q(eq8), .ERR_RCO(er8), .ERR_PAR(ep8),
        .ERR_STICKY(st8), .ERR_CNT(cnt8)
    );

    counter_checker #(.CNT_W(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .ENB(ENB), .D(D), .MODO(MODO), .Q(Q), .RCO(RCO),
        .Paridad(Paridad), .SYNC(sync2), .ERR_Q(eq2), .ERR_RCO(er2), .ERR_PAR(ep2),
        .ERR_STICKY(st2), .ERR_CNT(cnt2)
    );

    always #5 CLK = ~CLK;

    // One driven cycle: controls, planted faults and the expected checker flags.
    typedef struct packed {
        logic       rst;
        logic       enb;
        logic [3:0] d;
        logic [1:0] modo;
        logic       fq_en;
        logic [3:0] fq_val;
        logic       frco;
        logic       fpar;
        logic       sync;
        logic       eq;
        logic       er;
        logic       ep;
    } vec_t;

    typedef struct packed {
        logic       sync;
        logic       eq;
        logic       er;
        logic       ep;
        logic       sticky;
        logic [7:0] cnt8;
        logic [1:0] cnt2;
    } exp_t;

    exp_t       sb[$];
    vec_t       tbl[$];
    logic [3:0] q_c = 4'h7;
    logic       p_c = 1'b0;
    logic [7:0] cnt8_e = 8'd0;
    logic [1:0] cnt2_e = 2'd0;
    logic       sticky_e = 1'b0;

    function automatic vec_t mk(input logic rst, input logic enb, input logic [3:0] d,
                                input logic [1:0] modo, input logic fq_en,
                                input logic [3:0] fq_val, input logic frco, input logic fpar,
                                input logic sync, input logic eq, input logic er,
                                input logic ep);
        vec_t v;
        v = {rst, enb, d, modo, fq_en, fq_val, frco, fpar, sync, eq, er, ep};
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input vec_t v);
        exp_t e;
        logic ep_eff;
        logic any;
        @(negedge CLK);
        if (v.fq_en) q_c = v.fq_val;
        if (v.fpar)  p_c = ~p_c;
        RESET   = v.rst;
        ENB     = v.enb;
        D       = v.d;
        MODO    = v.modo;
        Q       = q_c;
        RCO     = (q_c == 4'hF) ^ v.frco;
        Paridad = p_c;
        ep_eff  = PAR_ON ? v.ep : 1'b0;
        any     = v.eq | v.er | ep_eff;
        if (v.rst) begin
            cnt8_e = 8'd0; cnt2_e = 2'd0; sticky_e = 1'b0;
        end else if (any) begin
            if (cnt8_e != 8'hFF) cnt8_e = cnt8_e + 8'd1;
            if (cnt2_e != 2'd3)  cnt2_e = cnt2_e + 2'd1;
            sticky_e = 1'b1;
        end
        e = {v.sync, v.eq, v.er, ep_eff, sticky_e, cnt8_e, cnt2_e};
        sb.push_back(e);
        @(posedge CLK);
        #1;
        // Behavioural counter: parity folds in the old value, then Q steps.
        if (ENB) begin
            p_c = p_c ^ (^q_c);
            case (MODO)
                2'b00:   q_c = q_c + 4'd1;
                2'b01:   q_c = q_c - 4'd1;
                2'b10:   q_c = q_c + 4'd3;
                default: q_c = D;
            endcase
        end
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk("sync8",   {7'd0, sync8}, {7'd0, e.sync});
            chk("err_q8",  {7'd0, eq8},   {7'd0, e.eq});
            chk("err_rco8",{7'd0, er8},   {7'd0, e.er});
            chk("err_par8",{7'd0, ep8},   {7'd0, e.ep});
            chk("sticky8", {7'd0, st8},   {7'd0, e.sticky});
            chk("cnt8",    cnt8,          e.cnt8);
            chk("sync2",   {7'd0, sync2}, {7'd0, e.sync});
            chk("err_q2",  {7'd0, eq2},   {7'd0, e.eq});
            chk("err_rco2",{7'd0, er2},   {7'd0, e.er});
            chk("err_par2",{7'd0, ep2},   {7'd0, e.ep});
            chk("sticky2", {7'd0, st2},   {7'd0, e.sticky});
            chk("cnt2",    {6'd0, cnt2},  {6'd0, e.cnt2});
        end
    endtask

    // Plain counting cycle in CHECK with no fault and no error expected.
    function automatic vec_t ok(input logic enb, input logic [3:0] d, input logic [1:0] modo);
        return mk(1'b0, enb, d, modo, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    initial begin
        logic [3:0] fault_vals [5];
        RESET = 1'b1; ENB = 1'b0; D = 4'h0; MODO = 2'b00; Q = 4'h0; RCO = 1'b0; Paridad = 1'b0;

        // Reset, free running without load, then sync and correct counting.
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 4'h3, 2'b11, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(ok(1'b1, 4'hD, 2'b11));   // sync load D
        tbl.push_back(ok(1'b1, 4'h0, 2'b10));   // Q=D -> 0
        tbl.push_back(ok(1'b1, 4'h0, 2'b10));   // Q=0 -> 3
        tbl.push_back(ok(1'b1, 4'hF, 2'b11));   // Q=3 -> F
        tbl.push_back(ok(1'b1, 4'h0, 2'b00));   // Q=F, RCO=1 -> 0
        tbl.push_back(ok(1'b1, 4'h0, 2'b00));   // Q=0 -> 1
        tbl.push_back(ok(1'b0, 4'h0, 2'b00));   // hold 1
        tbl.push_back(ok(1'b0, 4'h9, 2'b11));   // hold 1, load ignored
        tbl.push_back(ok(1'b0, 4'h0, 2'b00));   // hold 1
        tbl.push_back(ok(1'b1, 4'h0, 2'b11));   // Q=1 -> 0
        tbl.push_back(ok(1'b1, 4'h0, 2'b01));   // Q=0 -> F
        tbl.push_back(ok(1'b1, 4'h0, 2'b01));   // Q=F -> E
        tbl.push_back(ok(1'b1, 4'h0, 2'b10));   // Q=E -> 1
        tbl.push_back(ok(1'b1, 4'hF, 2'b11));   // Q=1 -> F
        tbl.push_back(ok(1'b1, 4'h0, 2'b10));   // Q=F -> 2
        tbl.push_back(ok(1'b1, 4'hD, 2'b11));   // Q=2 -> D
        tbl.push_back(ok(1'b1, 4'h0, 2'b10));   // Q=D -> 0
        for (int i = 0; i < 6; i++)
            tbl.push_back(ok(1'b1, 4'h0, 2'b00)); // Q=0..5 -> 6
        foreach (tbl[i]) step(tbl[i]);

        // Expected 6, counter corrupted to 5: one ERR_Q, then clean from 5.
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(ok(1'b1, 4'h0, 2'b00));
        step(ok(1'b1, 4'h0, 2'b00));
        // Q=F with RCO dropped and parity flipped on the same edge.
        step(ok(1'b1, 4'hF, 2'b11));
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
        step(ok(1'b1, 4'h0, 2'b00));
        // RCO raised while Q=1.
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
        step(ok(1'b1, 4'h0, 2'b00));
        // Q fault while disabled.
        step(mk(1'b0, 1'b0, 4'h0, 2'b00, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
        step(ok(1'b1, 4'h0, 2'b00));
        // Five separate Q faults: the 2-bit counter saturates at 3.
        fault_vals[0] = 4'h0; fault_vals[1] = 4'h9; fault_vals[2] = 4'h4;
        fault_vals[3] = 4'hC; fault_vals[4] = 4'h1;
        for (int i = 0; i < 5; i++) begin
            step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b1, fault_vals[i], 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
            step(ok(1'b1, 4'h0, 2'b00));
        end
        // Q and RCO wrong together: counted once.
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        step(ok(1'b1, 4'h0, 2'b00));
        // Reset mid-CHECK, faults ignored until a new load.
        step(mk(1'b1, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b1, 4'h9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        step(ok(1'b1, 4'h4, 2'b11));
        step(ok(1'b1, 4'h0, 2'b01));
        step(ok(1'b1, 4'h0, 2'b00));
        // Parity-only fault.
        step(mk(1'b0, 1'b1, 4'h0, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
        step(ok(1'b1, 4'h0, 2'b00));
        step(ok(1'b1, 4'h0, 2'b00));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
